// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Pipeline sequencer for the 5-stage RV32I core (IF/DE/EX/ME/WB).
//
// Responsibilities:
//   - Holds the PC for BOOT_CYCLES clocks after reset release.
//   - Detects load-use hazards and inserts a single bubble.
//   - Flushes the two younger stages on a taken branch or jump.
//   - Drains and freezes the pipeline on a debug halt request.
//   - Produces the EX-stage forwarding selects, registered alongside DE/EX.
//
// A small internal scoreboard shadows rd/write/load/valid for the
// instructions currently in EX and ME. This lets the hazard and forwarding
// logic run without tapping the datapath pipeline registers.
//
// Optional feature (compile-time macro HAZARD_PERF_EN):
//   Adds saturating stall_cnt / flush_cnt performance counters.
//   With the macro undefined, those ports and counters do not exist.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   de_rs1/2     source register addresses of the DE-stage instruction
//   de_use_rs1/2 DE instruction actually reads rs1 / rs2
//   de_rd        destination register of the DE instruction
//   de_ru_write  DE instruction writes rd
//   de_is_load   DE instruction is a load
//   ex_br_taken  branch/jump in EX resolved taken
//   halt_req     debug halt request (level)
//   pc_en        PC may update
//   if_de_en     IF/DE register may load
//   if_de_flush  IF/DE loads a NOP bubble
//   de_ex_flush  DE/EX loads a bubble
//   fwd_a_sel    EX operand A source: 00 regfile, 01 ME ALU result, 10 WB data
//   fwd_b_sel    EX operand B / store-data source, same encoding
//   halted       pipeline drained and frozen
//   dbg_state    current FSM state (BOOT=0, RUN=1, DRAIN=2, HALTED=3)
//   stall_cnt    (HAZARD_PERF_EN only) load-use stall cycles, saturating
//   flush_cnt    (HAZARD_PERF_EN only) taken-branch flush cycles, saturating
// -----------------------------------------------------------------------------
module hazard_controller #(
  parameter int BOOT_CYCLES = 4,
  parameter int RA_W        = 5
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] de_rs1,
  input  logic [RA_W-1:0] de_rs2,
  input  logic            de_use_rs1,
  input  logic            de_use_rs2,
  input  logic [RA_W-1:0] de_rd,
  input  logic            de_ru_write,
  input  logic            de_is_load,
  input  logic            ex_br_taken,
  input  logic            halt_req,
  output logic            pc_en,
  output logic            if_de_en,
  output logic            if_de_flush,
  output logic            de_ex_flush,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel,
  output logic            halted,
  output logic [1:0]      dbg_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // Counter only needs to reach BOOT_CYCLES-1.
  localparam int BC_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  state_t            state;
  state_t            state_nxt;
  logic [BC_W-1:0]   boot_cnt;
  logic              boot_done;

  // Scoreboard: EX and ME stage shadows.
  logic [RA_W-1:0]   ex_rd;
  logic              ex_wr;
  logic              ex_ld;
  logic              ex_valid;
  logic [RA_W-1:0]   me_rd;
  logic              me_wr;
  logic              me_valid;

  logic              load_use;
  logic              sb_empty;
  logic              stall;
  logic              br_flush;
  logic [1:0]        fwd_a_nxt;
  logic [1:0]        fwd_b_nxt;

  assign boot_done = (boot_cnt == BC_W'(BOOT_CYCLES - 1));
  assign dbg_state = state;

  // A load to x0 never produces a usable value, so it never causes a stall.
  assign load_use = ex_ld && ex_wr && (ex_rd != '0) &&
                    ((de_use_rs1 && (de_rs1 == ex_rd)) ||
                     (de_use_rs2 && (de_rs2 == ex_rd)));

  assign sb_empty = !(ex_wr || me_wr || ex_valid || me_valid);

  // ---------------------------------------------------------------------------
  // FSM next state and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    pc_en       = 1'b0;
    if_de_en    = 1'b0;
    if_de_flush = 1'b0;
    de_ex_flush = 1'b0;
    halted      = 1'b0;
    stall       = 1'b0;
    br_flush    = 1'b0;

    case (state)
      ST_BOOT: begin
        if_de_flush = 1'b1;
        de_ex_flush = 1'b1;
        if (boot_done) begin
          state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        pc_en    = 1'b1;
        if_de_en = 1'b1;
        // A taken branch kills the DE instruction, so any load-use hazard it
        // carries is irrelevant. The flush therefore wins over the stall.
        if (ex_br_taken) begin
          if_de_flush = 1'b1;
          de_ex_flush = 1'b1;
          br_flush    = 1'b1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_de_en    = 1'b0;
          de_ex_flush = 1'b1;
          stall       = 1'b1;
        end
        if (halt_req) begin
          state_nxt = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Nothing new enters EX. A branch still resolving in EX must redirect
        // the PC so that fetch resumes at the right place after the halt.
        de_ex_flush = 1'b1;
        if (ex_br_taken) begin
          pc_en       = 1'b1;
          if_de_en    = 1'b1;
          if_de_flush = 1'b1;
          br_flush    = 1'b1;
        end
        if (!halt_req) begin
          state_nxt = ST_RUN;
        end else if (sb_empty) begin
          state_nxt = ST_HALTED;
        end
      end

      ST_HALTED: begin
        de_ex_flush = 1'b1;
        halted      = 1'b1;
        if (!halt_req) begin
          state_nxt = ST_RUN;
        end
      end

      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Forwarding select for the instruction about to enter EX.
  // EX-stage loads are skipped: their data is not available until WB, and the
  // load-use stall guarantees they have moved on to ME by the time they
  // are needed.
  // ---------------------------------------------------------------------------
  always_comb begin
    fwd_a_nxt = 2'b00;
    fwd_b_nxt = 2'b00;

    if (de_rs1 != '0) begin
      if (ex_wr && !ex_ld && (ex_rd == de_rs1)) begin
        fwd_a_nxt = 2'b01;
      end else if (me_wr && (me_rd == de_rs1)) begin
        fwd_a_nxt = 2'b10;
      end
    end

    if (de_rs2 != '0) begin
      if (ex_wr && !ex_ld && (ex_rd == de_rs2)) begin
        fwd_b_nxt = 2'b01;
      end else if (me_wr && (me_rd == de_rs2)) begin
        fwd_b_nxt = 2'b10;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State, boot counter, scoreboard and forwarding registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_BOOT;
      boot_cnt  <= '0;
      ex_rd     <= '0;
      ex_wr     <= 1'b0;
      ex_ld     <= 1'b0;
      ex_valid  <= 1'b0;
      me_rd     <= '0;
      me_wr     <= 1'b0;
      me_valid  <= 1'b0;
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
    end else begin
      state <= state_nxt;

      if ((state == ST_BOOT) && !boot_done) begin
        boot_cnt <= boot_cnt + BC_W'(1);
      end else begin
        boot_cnt <= '0;
      end

      me_rd    <= ex_rd;
      me_wr    <= ex_wr;
      me_valid <= ex_valid;

      if (de_ex_flush) begin
        ex_rd     <= '0;
        ex_wr     <= 1'b0;
        ex_ld     <= 1'b0;
        ex_valid  <= 1'b0;
        fwd_a_sel <= 2'b00;
        fwd_b_sel <= 2'b00;
      end else begin
        ex_rd     <= de_rd;
        ex_wr     <= de_ru_write;
        ex_ld     <= de_is_load;
        ex_valid  <= 1'b1;
        fwd_a_sel <= fwd_a_nxt;
        fwd_b_sel <= fwd_b_nxt;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (br_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
//
// Directed bench for hazard_controller. It covers:
//   - the boot hold;
//   - a per-cycle vector table (stall, forwarding, x0, branch-over-stall);
//   - hand-written halt/drain, halt abort and async-reset sequences.
//
// Inputs are driven on the falling edge. Outputs are sampled 2 time units
// later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_controller;

  localparam int RA_W = 5;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [RA_W-1:0] de_rs1;
  logic [RA_W-1:0] de_rs2;
  logic            de_use_rs1;
  logic            de_use_rs2;
  logic [RA_W-1:0] de_rd;
  logic            de_ru_write;
  logic            de_is_load;
  logic            ex_br_taken;
  logic            halt_req;
  logic            pc_en;
  logic            if_de_en;
  logic            if_de_flush;
  logic            de_ex_flush;
  logic [1:0]      fwd_a_sel;
  logic [1:0]      fwd_b_sel;
  logic            halted;
  logic [1:0]      dbg_state;
`ifdef HAZARD_PERF_EN
  logic [31:0]     stall_cnt;
  logic [31:0]     flush_cnt;
`endif

  hazard_controller #(
    .BOOT_CYCLES (4),
    .RA_W        (RA_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .de_rs1      (de_rs1),
    .de_rs2      (de_rs2),
    .de_use_rs1  (de_use_rs1),
    .de_use_rs2  (de_use_rs2),
    .de_rd       (de_rd),
    .de_ru_write (de_ru_write),
    .de_is_load  (de_is_load),
    .ex_br_taken (ex_br_taken),
    .halt_req    (halt_req),
    .pc_en       (pc_en),
    .if_de_en    (if_de_en),
    .if_de_flush (if_de_flush),
    .de_ex_flush (de_ex_flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .halted      (halted),
    .dbg_state   (dbg_state)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  // exp packing: {pc_en, if_de_en, if_de_flush, de_ex_flush,
  //               fwd_a_sel[1:0], fwd_b_sel[1:0], halted}
  typedef struct {
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic            u1;
    logic            u2;
    logic [RA_W-1:0] rd;
    logic            wr;
    logic            ld;
    logic            br;
    logic            halt;
    logic [8:0]      exp;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs[NVEC];

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [8:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input int rs1, input int rs2, input bit u1,
                              input bit u2, input int rd, input bit wr,
                              input bit ld, input bit br, input bit halt,
                              input logic [8:0] exp);
    vec_t v;
    v.rs1  = RA_W'(rs1);
    v.rs2  = RA_W'(rs2);
    v.u1   = u1;
    v.u2   = u2;
    v.rd   = RA_W'(rd);
    v.wr   = wr;
    v.ld   = ld;
    v.br   = br;
    v.halt = halt;
    v.exp  = exp;
    return v;
  endfunction

  function automatic logic [8:0] obs();
    return {pc_en, if_de_en, if_de_flush, de_ex_flush, fwd_a_sel, fwd_b_sel, halted};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input vec_t v);
    de_rs1      = v.rs1;
    de_rs2      = v.rs2;
    de_use_rs1  = v.u1;
    de_use_rs2  = v.u2;
    de_rd       = v.rd;
    de_ru_write = v.wr;
    de_is_load  = v.ld;
    ex_br_taken = v.br;
    halt_req    = v.halt;
  endtask

  task automatic drive_nop(input bit halt);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, halt, 9'b0));
  endtask

  // Advance to the next falling edge and let combinational outputs settle.
  task automatic next_sample();
    @(negedge clk);
    #2;
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------------------
  initial begin
    int  wait_cyc;
    bit  got_halt;

    // Each row: DE inputs for the cycle and outputs expected in that cycle.
    // fwd_* shows what the previous row's DE instruction loaded with DE/EX.
    //                rs1 rs2 u1 u2 rd wr ld br h   pc en ifl dfl fa fb h
    vecs[0]  = mk( 1, 0, 1, 0,  5, 1, 1, 0, 0, 9'b1_1_0_0_00_00_0); // lw x5,0(x1)
    vecs[1]  = mk( 5, 2, 1, 1,  6, 1, 0, 0, 0, 9'b0_0_0_1_00_00_0); // add x6,x5,x2: stall
    vecs[2]  = mk( 5, 2, 1, 1,  6, 1, 0, 0, 0, 9'b1_1_0_0_00_00_0); // add retried
    vecs[3]  = mk( 1, 2, 1, 1,  3, 1, 0, 0, 0, 9'b1_1_0_0_10_00_0); // add x3,x1,x2; add has A=WB
    vecs[4]  = mk( 3, 3, 1, 1,  4, 1, 0, 0, 0, 9'b1_1_0_0_00_00_0); // sub x4,x3,x3
    vecs[5]  = mk( 0, 0, 1, 0,  0, 1, 0, 0, 0, 9'b1_1_0_0_01_01_0); // addi x0,x0,5; sub A=B=ME
    vecs[6]  = mk( 0, 0, 1, 1,  7, 1, 0, 0, 0, 9'b1_1_0_0_00_00_0); // add x7,x0,x0
    vecs[7]  = mk( 1, 0, 1, 0,  0, 1, 1, 0, 0, 9'b1_1_0_0_00_00_0); // lw x0; x0 never forwarded
    vecs[8]  = mk( 0, 7, 1, 1,  8, 1, 0, 0, 0, 9'b1_1_0_0_00_00_0); // add x8,x0,x7: no stall on x0
    vecs[9]  = mk( 8, 0, 1, 0,  9, 1, 1, 0, 0, 9'b1_1_0_0_00_10_0); // lw x9,0(x8); add B=WB
    vecs[10] = mk( 2, 9, 1, 1,  0, 0, 0, 0, 0, 9'b0_0_0_1_01_00_0); // sw x9: stall via rs2
    vecs[11] = mk( 2, 9, 1, 1,  0, 0, 0, 0, 0, 9'b1_1_0_0_00_00_0); // sw retried
    vecs[12] = mk( 1, 0, 1, 0,  5, 1, 1, 0, 0, 9'b1_1_0_0_00_10_0); // lw x5; sw data=WB
    vecs[13] = mk( 5, 2, 1, 1,  6, 1, 0, 1, 0, 9'b1_1_1_1_00_00_0); // hazard + taken branch
    vecs[14] = mk( 1, 0, 1, 0,  5, 1, 1, 0, 0, 9'b1_1_0_0_00_00_0); // lw x5
    vecs[15] = mk( 1, 5, 1, 0,  6, 1, 0, 0, 0, 9'b1_1_0_0_00_00_0); // rs2 field unused: no stall
    vecs[16] = mk( 0, 0, 0, 0,  0, 0, 0, 0, 0, 9'b1_1_0_0_00_00_0); // nop
    vecs[17] = mk( 6, 6, 1, 1, 11, 1, 0, 0, 0, 9'b1_1_0_0_00_00_0); // add x11,x6,x6
    vecs[18] = mk( 0, 0, 0, 0,  0, 0, 0, 0, 0, 9'b1_1_0_0_10_10_0); // add11 got A=B=WB

    // --- Reset held low for 3 clocks --------------------------------------
    reset = 1'b0;
    drive_nop(1'b0);
    for (int i = 0; i < 3; i++) begin
      next_sample();
      check($sformatf("reset_outputs_%0d", i), 32'(obs()), 32'(9'b0_0_1_1_00_00_0));
    end
    check("reset_state", 32'(dbg_state), 32'd0);

    // --- Boot hold: pc_en low for exactly 4 clocks after release ----------
    @(negedge clk);
    reset = 1'b1;
    #2;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_sample();
      check($sformatf("boot_hold_%0d", i), 32'({pc_en, if_de_flush, de_ex_flush}), 32'(3'b011));
    end
    next_sample();
    check("boot_release", 32'({pc_en, if_de_en, if_de_flush, de_ex_flush}), 32'(4'b1100));
    check("run_state", 32'(dbg_state), 32'd1);

    // --- Per-cycle vector table -------------------------------------------
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      exp_q.push_back(vecs[i].exp);
      #2;
      check($sformatf("vec_%0d", i), 32'(obs()), 32'(exp_q.pop_front()));
    end

`ifdef HAZARD_PERF_EN
    check("stall_cnt", stall_cnt, 32'd2);
    check("flush_cnt", flush_cnt, 32'd1);
`endif

    // --- Halt with two instructions in flight -----------------------------
    // EX holds a nop and ME holds add x11 on entry; add x12 issues this cycle.
    @(negedge clk);
    drive(mk(1, 2, 1, 1, 12, 1, 0, 0, 1, 9'b0));
    #2;
    check("halt_req_run_cycle", 32'({pc_en, halted}), 32'(2'b10));
    @(negedge clk);
    drive_nop(1'b1);
    #2;
    got_halt = 1'b0;
    wait_cyc = 0;
    while (!got_halt && wait_cyc < 8) begin
      if (halted) begin
        got_halt = 1'b1;
      end else begin
        check($sformatf("drain_ctrl_%0d", wait_cyc),
              32'({pc_en, if_de_en, if_de_flush, de_ex_flush}), 32'(4'b0001));
        next_sample();
        wait_cyc++;
      end
    end
    check("halt_reached", 32'(got_halt), 32'd1);
    check("halted_outputs", 32'(obs()), 32'(9'b0_0_0_1_00_00_1));
    check("halted_state", 32'(dbg_state), 32'd3);

    // Release: still halted this cycle, RUN with pc_en=1 on the next.
    @(negedge clk);
    drive_nop(1'b0);
    #2;
    check("release_cycle", 32'({pc_en, halted}), 32'(2'b01));
    next_sample();
    check("resume_run", 32'({pc_en, if_de_en, de_ex_flush, halted}), 32'(4'b1100));

    // --- Halt dropped during DRAIN before the pipeline empties -----------
    @(negedge clk);
    drive(mk(1, 2, 1, 1, 13, 1, 0, 0, 1, 9'b0));
    #2;
    check("abort_run_cycle", 32'(pc_en), 32'd1);
    @(negedge clk);
    drive_nop(1'b0);
    #2;
    check("abort_drain_cycle", 32'({pc_en, de_ex_flush, halted}), 32'(3'b010));
    next_sample();
    check("abort_back_to_run", 32'({pc_en, if_de_en, de_ex_flush}), 32'(3'b110));

    // --- Async reset in the middle of a load-use stall -------------------
    @(negedge clk);
    drive(mk(1, 0, 1, 0, 5, 1, 1, 0, 0, 9'b0));
    @(negedge clk);
    drive(mk(5, 2, 1, 1, 6, 1, 0, 0, 0, 9'b0));
    #2;
    check("pre_reset_stall", 32'({pc_en, de_ex_flush}), 32'(2'b01));
    reset = 1'b0;
    #1;
    check("async_reset_outputs", 32'(obs()), 32'(9'b0_0_1_1_00_00_0));
    check("async_reset_state", 32'(dbg_state), 32'd0);
`ifdef HAZARD_PERF_EN
    check("stall_cnt_reset", stall_cnt, 32'd0);
`endif

    // --- Report -----------------------------------------------------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
